// File: rtl/tcm_banked_dp_if.sv
// Requester-side bus of the banked TCM: request/grant handshake plus response channel.
// Latency: none (wires only).
// Backpressure: requester holds req and its fields stable until gnt.
interface tcm_banked_dp_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tcm_banked_dp.sv
// Dual-port banked TCM: ports A/B hit single-port banks in parallel, round-robin per bank on collision.
// Latency: response 1 cycle after grant (OUT_REG=0) or 2 cycles (OUT_REG=1); one response per grant.
// Backpressure: combinational gnt; a losing port holds its request and wins the next contended cycle.
module tcm_banked_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter int BANK_DEPTH = 512,
    parameter bit OUT_REG    = 1'b0,
    parameter int ADDR_WIDTH = $clog2(DEPTH * DATA_WIDTH / 8)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    tcm_banked_dp_if.slave  a,
    tcm_banked_dp_if.slave  b
);
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(BE_W);
    localparam int WORD_W    = ADDR_WIDTH - OFF_W;
    localparam int NUM_BANKS = DEPTH / BANK_DEPTH;
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

    logic [WORD_W-1:0] a_word, b_word;
    logic [BANK_W-1:0] a_bank, b_bank;
    logic [ROW_W-1:0]  a_row, b_row;

    assign a_word = a.addr[ADDR_WIDTH-1:OFF_W];
    assign b_word = b.addr[ADDR_WIDTH-1:OFF_W];
    assign a_row  = a_word[ROW_W-1:0];
    assign b_row  = b_word[ROW_W-1:0];

    generate
        if (NUM_BANKS > 1) begin : g_bank_sel
            assign a_bank = a_word[WORD_W-1 -: BANK_W];
            assign b_bank = b_word[WORD_W-1 -: BANK_W];
        end else begin : g_single_bank
            assign a_bank = '0;
            assign b_bank = '0;
        end
        if (OFF_W > 0) begin : g_byte_off
            logic [OFF_W-1:0] unused_off;
            assign unused_off = a.addr[OFF_W-1:0] ^ b.addr[OFF_W-1:0];
        end
    endgenerate

    // prio[bank]: 0 = A wins the next collision on that bank, 1 = B wins.
    logic [NUM_BANKS-1:0] prio;
    logic                 contend;
    logic                 a_gnt, b_gnt;

    assign contend = a.req && b.req && (a_bank == b_bank);

    always_comb begin
        a_gnt = !rst_i && a.req && (!contend || !prio[a_bank]);
        b_gnt = !rst_i && b.req && (!contend ||  prio[b_bank]);
    end

    assign a.gnt = a_gnt;
    assign b.gnt = b_gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio <= '0;
        end else if (contend) begin
            prio[a_bank] <= !prio[a_bank];
        end
    end

    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  sel_a, sel_b, en, we;
        logic [ROW_W-1:0]      row;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;

        // Arbitration guarantees at most one of sel_a/sel_b per bank.
        assign sel_a = a_gnt && (a_bank == BANK_W'(k));
        assign sel_b = b_gnt && (b_bank == BANK_W'(k));
        assign en    = sel_a || sel_b;
        assign we    = sel_a ? a.we    : b.we;
        assign row   = sel_a ? a_row   : b_row;
        assign be    = sel_a ? a.be    : b.be;
        assign wdata = sel_a ? a.wdata : b.wdata;

        always_ff @(posedge clk_i) begin
            if (en) begin
                if (we) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (be[i]) begin
                            mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem[row];
                end
            end
        end

        assign bank_rdata[k] = rdata_q;
    end

    // Response stage: bank index captured at grant steers the read mux.
    logic              a_vld1, b_vld1, a_rd1, b_rd1;
    logic [BANK_W-1:0] a_bank1, b_bank1;
    logic [DATA_WIDTH-1:0] a_dat1, b_dat1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_vld1  <= 1'b0;
            b_vld1  <= 1'b0;
            a_rd1   <= 1'b0;
            b_rd1   <= 1'b0;
            a_bank1 <= '0;
            b_bank1 <= '0;
        end else begin
            a_vld1  <= a_gnt;
            b_vld1  <= b_gnt;
            a_rd1   <= a_gnt && !a.we;
            b_rd1   <= b_gnt && !b.we;
            a_bank1 <= a_bank;
            b_bank1 <= b_bank;
        end
    end

    assign a_dat1 = a_rd1 ? bank_rdata[a_bank1] : '0;
    assign b_dat1 = b_rd1 ? bank_rdata[b_bank1] : '0;

    generate
        if (OUT_REG) begin : g_out_reg
            logic                  a_vld2, b_vld2;
            logic [DATA_WIDTH-1:0] a_dat2, b_dat2;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_vld2 <= 1'b0;
                    b_vld2 <= 1'b0;
                    a_dat2 <= '0;
                    b_dat2 <= '0;
                end else begin
                    a_vld2 <= a_vld1;
                    b_vld2 <= b_vld1;
                    a_dat2 <= a_dat1;
                    b_dat2 <= b_dat1;
                end
            end

            assign a.rvalid = a_vld2;
            assign b.rvalid = b_vld2;
            assign a.rdata  = a_dat2;
            assign b.rdata  = b_dat2;
        end else begin : g_no_out_reg
            assign a.rvalid = a_vld1;
            assign b.rvalid = b_vld1;
            assign a.rdata  = a_dat1;
            assign b.rdata  = b_dat1;
        end
    endgenerate
endmodule

// File: tb/tb_tcm_banked_dp.sv
// Bench for tcm_banked_dp: a default instance (latency 1) and a small OUT_REG=1 instance (latency 2),
// each checked every cycle against a word-level memory/arbitration model, plus literal spot checks.
module tb_tcm_banked_dp;
    logic clk = 1'b0;
    logic rst0, rst1;
    logic chk_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    tcm_banked_dp_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) ia0 ();
    tcm_banked_dp_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) ib0 ();
    tcm_banked_dp_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) ia1 ();
    tcm_banked_dp_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) ib1 ();

    tcm_banked_dp #(.OUT_REG(1'b0)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .a     (ia0),
        .b     (ib0)
    );

    tcm_banked_dp #(.DEPTH(1024), .BANK_DEPTH(256), .OUT_REG(1'b1)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .a     (ia1),
        .b     (ib1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Model state: word memory keyed by dut*65536+word, per-bank priority, response schedule per port.
    logic [31:0] mem [int];
    bit          prio [2][16];
    bit          sv [4][8];
    bit          sknown [4][8];
    logic [31:0] sdat [4][8];

    task automatic step(input int d, input int lat, input int bsh, input logic rst,
                        input logic ar, input logic br, input logic awe, input logic bwe,
                        input int aad, input int bad, input logic [3:0] abe, input logic [3:0] bbe,
                        input logic [31:0] awd, input logic [31:0] bwd,
                        input logic ag, input logic bg, input logic av, input logic bv,
                        input logic [31:0] ard, input logic [31:0] brd);
        logic        r [2], w [2], g [2], v [2];
        int          ad [2], bank [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2], rd [2], old;
        bit          eg [2], cont;
        int          slot, ns, k, key;
        string       pn;
        r = '{ar, br};  w = '{awe, bwe};  g = '{ag, bg};  v = '{av, bv};
        ad = '{aad, bad};  be = '{abe, bbe};  wd = '{awd, bwd};  rd = '{ard, brd};
        for (int p = 0; p < 2; p++) bank[p] = (ad[p] >> 2) >> bsh;
        cont = r[0] && r[1] && (bank[0] == bank[1]);
        eg[0] = !rst && r[0] && (!cont || !prio[d][bank[0]]);
        eg[1] = !rst && r[1] && (!cont ||  prio[d][bank[1]]);
        slot = cyc % 8;
        for (int p = 0; p < 2; p++) begin
            pn = $sformatf("d%0d_%s", d, (p == 0) ? "a" : "b");
            k = d * 2 + p;
            chk1({pn, "_gnt"}, g[p], eg[p]);
            chk1({pn, "_rvalid"}, v[p], sv[k][slot]);
            if (!sv[k][slot]) chk({pn, "_rdata_idle"}, rd[p], 32'd0);
            else if (sknown[k][slot]) chk({pn, "_rdata"}, rd[p], sdat[k][slot]);
            sv[k][slot] = 1'b0;
        end
        if (rst) begin
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < 8; s++) sv[d*2+p][s] = 1'b0;
            for (int bk = 0; bk < 16; bk++) prio[d][bk] = 1'b0;
        end else begin
            if (cont) prio[d][bank[0]] = !prio[d][bank[0]];
            ns = (cyc + lat) % 8;
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) begin
                    k = d * 2 + p;
                    key = d * 65536 + (ad[p] >> 2);
                    sv[k][ns] = 1'b1;
                    if (w[p]) begin
                        sdat[k][ns] = 32'd0;
                        sknown[k][ns] = 1'b1;
                        if (mem.exists(key) || be[p] == 4'hF) begin
                            old = mem.exists(key) ? mem[key] : 32'd0;
                            for (int i = 0; i < 4; i++)
                                if (be[p][i]) old[i*8 +: 8] = wd[p][i*8 +: 8];
                            mem[key] = old;
                        end
                    end else begin
                        sknown[k][ns] = mem.exists(key);
                        sdat[k][ns] = mem.exists(key) ? mem[key] : 32'd0;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            step(0, 1, 9, rst0, ia0.req, ib0.req, ia0.we, ib0.we, int'(ia0.addr), int'(ib0.addr),
                 ia0.be, ib0.be, ia0.wdata, ib0.wdata, ia0.gnt, ib0.gnt, ia0.rvalid, ib0.rvalid,
                 ia0.rdata, ib0.rdata);
            step(1, 2, 8, rst1, ia1.req, ib1.req, ia1.we, ib1.we, int'(ia1.addr), int'(ib1.addr),
                 ia1.be, ib1.be, ia1.wdata, ib1.wdata, ia1.gnt, ib1.gnt, ia1.rvalid, ib1.rvalid,
                 ia1.rdata, ib1.rdata);
        end
    end

    // Port index: 0 = dut0.A, 1 = dut0.B, 2 = dut1.A, 3 = dut1.B.
    task automatic drv(input int p, input logic r, input logic w, input logic [31:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
        case (p)
            0: begin ia0.req = r; ia0.we = w; ia0.addr = ad[14:0]; ia0.be = be; ia0.wdata = wd; end
            1: begin ib0.req = r; ib0.we = w; ib0.addr = ad[14:0]; ib0.be = be; ib0.wdata = wd; end
            2: begin ia1.req = r; ia1.we = w; ia1.addr = ad[11:0]; ia1.be = be; ia1.wdata = wd; end
            default: begin ib1.req = r; ib1.we = w; ib1.addr = ad[11:0]; ib1.be = be; ib1.wdata = wd; end
        endcase
    endtask

    task automatic idle(input int p);
        drv(p, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    endtask
    task automatic rd(input int p, input logic [31:0] ad);
        drv(p, 1'b1, 1'b0, ad, 4'h0, 32'd0);
    endtask
    task automatic wr(input int p, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd);
        drv(p, 1'b1, 1'b1, ad, be, wd);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pa, pb;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int p = 0; p < 4; p++) idle(p);
        tick();
        chk_en = 1'b1;
        rd(0, 32'h0);
        #3 chk1("gnt_low_in_reset", ia0.gnt, 1'b0);
        tick();
        idle(0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Write then read back on A.
        tick(); wr(0, 32'h0, 4'hF, 32'hDEADBEEF);
        #3 chk1("a_wr_gnt", ia0.gnt, 1'b1);
        tick(); rd(0, 32'h0);
        #3 chk1("a_wr_rvalid", ia0.rvalid, 1'b1);
        chk("a_wr_rdata_zero", ia0.rdata, 32'h0);
        tick(); idle(0);
        #3 chk1("a_rd_rvalid", ia0.rvalid, 1'b1);
        chk("a_rd_deadbeef", ia0.rdata, 32'hDEADBEEF);

        tick(); wr(0, 32'h1000, 4'hF, 32'hA5A50002); wr(1, 32'h0800, 4'hF, 32'h12345678);
        #3 chk1("par_wr_b_gnt", ib0.gnt, 1'b1);
        tick(); idle(0); wr(1, 32'h1004, 4'hF, 32'h5A5A0003);

        // Different banks in the same cycle.
        tick(); rd(0, 32'h0); rd(1, 32'h0800);
        #3 chk1("par_a_gnt", ia0.gnt, 1'b1);
        chk1("par_b_gnt", ib0.gnt, 1'b1);
        tick(); idle(0); idle(1);
        #3 chk("par_a_data", ia0.rdata, 32'hDEADBEEF);
        chk("par_b_data", ib0.rdata, 32'h12345678);

        // Both ports hammer bank 2 for four cycles.
        for (int i = 0; i < 4; i++) begin
            tick(); rd(0, 32'h1000); rd(1, 32'h1004);
            #3 pa[3-i] = ia0.gnt;
            pb[3-i] = ib0.gnt;
        end
        tick(); idle(0); idle(1);
        #3 chk("alt_a_pattern", {28'd0, pa}, 32'hA);
        chk("alt_b_pattern", {28'd0, pb}, 32'h5);

        // Partial byte-enable write, then a be=0 write that must not disturb the word.
        tick(); wr(0, 32'h10, 4'hF, 32'hFFFFFFFF);
        tick(); wr(0, 32'h10, 4'b0101, 32'h11223344);
        tick(); wr(0, 32'h10, 4'h0, 32'h0);
        tick(); rd(0, 32'h10);
        tick(); idle(0);
        #3 chk("be_merge", ia0.rdata, 32'hFF22FF44);

        for (int i = 0; i < 3; i++) begin
            tick(); rd(1, (i == 0) ? 32'h0 : (i == 1) ? 32'h0800 : 32'h1004);
        end
        tick(); idle(1);

        // OUT_REG=1 instance: fill one word per bank, then stream reads.
        for (int i = 0; i < 4; i++) begin
            tick(); wr(2, i * 32'h400, 4'hF, 32'hB0000000 + i);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) rd(2, i * 32'h400);
            else idle(2);
            #3;
            if (i >= 2) begin
                chk1($sformatf("stream_rvalid_%0d", i - 2), ia1.rvalid, 1'b1);
                chk($sformatf("stream_rdata_%0d", i - 2), ia1.rdata, 32'hB0000000 + i - 2);
            end
        end

        // Collision on bank 0 leaves B with priority; a reset must hand it back to A.
        tick(); rd(2, 32'h0); rd(3, 32'h0);
        #3 chk1("pre_rst_a_wins", ia1.gnt, 1'b1);
        chk1("pre_rst_b_loses", ib1.gnt, 1'b0);
        tick(); idle(2);
        #3 chk1("b_wins_after_wait", ib1.gnt, 1'b1);
        tick(); idle(3); rd(2, 32'h400);
        tick(); rd(2, 32'h800);
        tick(); idle(2); rst1 = 1'b1;
        #3 chk1("gnt_low_rst_mid", ia1.gnt, 1'b0);
        tick(); rst1 = 1'b0; rd(2, 32'h0); rd(3, 32'h0);
        #3 chk1("dropped_rsp", ia1.rvalid, 1'b0);
        chk1("prio_reset_a", ia1.gnt, 1'b1);
        chk1("prio_reset_b", ib1.gnt, 1'b0);
        tick(); idle(2);
        tick(); idle(3); rd(2, 32'h400);
        tick(); idle(2);
        tick();
        #3 chk1("mem_kept_rvalid", ia1.rvalid, 1'b1);
        chk("mem_kept_rdata", ia1.rdata, 32'hB0000001);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
